// File: rtl/uart_tx_wrapper_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_wrapper_if
// Purpose  : Word handshake between a producer and the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_wrapper_if;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_wrapper
// Purpose  : Word FIFO feeding a UART 8N1 serializer, 4 bytes per word, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_wrapper #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_wrapper_if.slave bus,
  output logic             io_tx,
  output logic             busy,
  output logic             word_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_d;
  logic          data_ready_q, data_ready_d;

  state_t        state_q, state_d;
  logic [31:0]   shift_q, shift_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic          io_tx_q, io_tx_d;
  logic          word_done_q, word_done_d;

  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          baud_end;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign push       = bus.data_valid & data_ready_q;
  // Pop only from registered occupancy, so a fresh push is never popped on its own edge.
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign baud_end   = (baud_cnt_q == BAUD_MAX);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = bus.data_in;
    end
    count_d      = wr_ptr_d - rd_ptr_d;
    data_ready_d = (count_d != FULL_CNT);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    word_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q[AW-1:0]];
          byte_idx_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d  = '0;
            word_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the current state, so it lags the state register by one edge.
  always_comb begin
    io_tx_d = 1'b1;
    case (state_q)
      S_START: io_tx_d = 1'b0;
      S_DATA:  io_tx_d = shift_q[0];
      default: io_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_ready_q <= 1'b1;
      state_q      <= S_IDLE;
      shift_q      <= '0;
      baud_cnt_q   <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      io_tx_q      <= 1'b1;
      word_done_q  <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_ready_q <= data_ready_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      io_tx_q      <= io_tx_d;
      word_done_q  <= word_done_d;
    end
  end

  assign bus.data_ready = data_ready_q;
  assign io_tx          = io_tx_q;
  assign word_done      = word_done_q;
  assign busy           = (state_q != S_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_wrapper
// Purpose  : Self-checking bench: byte scoreboard against a UART line decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_wrapper;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic io_tx;
  logic busy;
  logic word_done;

  uart_tx_wrapper_if bus_if ();

  uart_tx_wrapper #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
    .io_tx     (io_tx),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int wd_count  = 0;
  int frame_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: sample mid-bit, counting negedges from the first low sample.
  int         m_cnt    = 0;
  bit         m_active = 1'b0;
  logic [7:0] m_byte   = '0;

  always @(negedge clk) begin
    if (word_done === 1'b1) wd_count <= wd_count + 1;
    if (!reset_n) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (io_tx === 1'b0) begin
        m_active <= 1'b1;
        m_cnt    <= 1;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == CPB / 2 && io_tx !== 1'b0) frame_err <= frame_err + 1;
      if (m_cnt >= CPB + CPB / 2 && m_cnt <= 8 * CPB + CPB / 2 && (m_cnt % CPB) == CPB / 2)
        m_byte[m_cnt / CPB - 1] <= io_tx;
      if (m_cnt == 9 * CPB + CPB / 2) begin
        if (io_tx !== 1'b1) frame_err <= frame_err + 1;
        rx_q.push_back(m_byte);
        m_active <= 1'b0;
      end
    end
  end

  task automatic push_word(input logic [31:0] w, output bit ok);
    ok = 1'b0;
    bus_if.data_in    = w;
    bus_if.data_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      logic r;
      r = bus_if.data_ready;
      @(posedge clk); #1;
      if (r) ok = 1'b1;
    end
    bus_if.data_valid = 1'b0;
    if (ok) for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy && rx_q.size() >= exp_q.size()) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (io_tx !== 1'b1) begin failures++; $display("FAIL reset_io_tx got=%b exp=1", io_tx); end
    checks++; if (bus_if.data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus_if.data_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL reset_word_done got=%b exp=0", word_done); end
  endtask

  task automatic test_single_word;
    logic [7:0]  b0;
    logic [31:0] w;
    int          wd0, bad;
    bit          ok;
    w   = 32'h1111_A5C3;
    b0  = w[7:0];
    wd0 = wd_count;
    bad = 0;
    bus_if.data_in    = w;
    bus_if.data_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.data_valid = 1'b0;
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_push got=%b exp=1", busy); end
    @(posedge clk); #1;
    checks++; if (io_tx !== 1'b1) begin failures++; $display("FAIL tx_high_at_pop got=%b exp=1", io_tx); end
    @(posedge clk); #1;
    checks++; if (io_tx !== 1'b0) begin failures++; $display("FAIL start_at_push_plus2 got=%b exp=0", io_tx); end
    for (int i = 0; i < 10 * CPB; i++) begin
      int   k;
      logic e;
      k = i / CPB;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b0[k-1];
      if (io_tx !== e) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL c3_waveform bad_samples got=%0d exp=0", bad); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=0 exp=1"); end
    checks++; if (wd_count - wd0 != 1) begin failures++; $display("FAIL single_word_done got=%0d exp=1", wd_count - wd0); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin failures++; $display("FAIL single_byte got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_back_to_back;
    int wd0, wd_at, fall_at;
    bit ok1, ok2, done;
    wd0     = wd_count;
    wd_at   = -1;
    fall_at = -1;
    done    = 1'b0;
    push_word(32'hDEAD_BEEF, ok1);
    push_word(32'h0000_0000, ok2);
    checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL b2b_push got=%0d%0d exp=11", ok1, ok2); end
    for (int i = 0; i < 5000 && !done; i++) begin
      @(posedge clk); #1;
      if (word_done === 1'b1 && wd_at < 0) wd_at = cyc;
      if (wd_at >= 0 && fall_at < 0 && cyc > wd_at && io_tx === 1'b0) fall_at = cyc;
      if (!busy) done = 1'b1;
    end
    wait_idle(ok1);
    checks++; if (!(done && ok1)) begin failures++; $display("FAIL b2b_timeout got=0 exp=1"); end
    checks++; if (fall_at - wd_at != 2) begin failures++; $display("FAIL b2b_gap got=%0d exp=2", fall_at - wd_at); end
    checks++; if (wd_count - wd0 != 2) begin failures++; $display("FAIL b2b_word_done got=%0d exp=2", wd_count - wd0); end
    checks++; if (rx_q.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", rx_q.size()); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin failures++; $display("FAIL b2b_byte got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_full_fifo;
    logic [31:0] words [6];
    int          acc_cyc [6];
    int          acc;
    bit          ok;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      words[i]   = $urandom;
      acc_cyc[i] = 0;
    end
    bus_if.data_in    = words[0];
    bus_if.data_valid = 1'b1;
    for (int i = 0; i < 3000 && acc < 6; i++) begin
      logic r;
      r = bus_if.data_ready;
      @(posedge clk); #1;
      if (r) begin
        for (int b = 0; b < 4; b++) exp_q.push_back(words[acc][8*b +: 8]);
        acc_cyc[acc] = cyc;
        acc++;
        if (acc == 5) begin
          checks++; if (bus_if.data_ready !== 1'b0) begin failures++; $display("FAIL ready_low_when_full got=%b exp=0", bus_if.data_ready); end
        end
        if (acc < 6) bus_if.data_in = words[acc];
      end
    end
    bus_if.data_valid = 1'b0;
    checks++; if (acc != 6) begin failures++; $display("FAIL full_accepts got=%0d exp=6", acc); end
    checks++; if (acc_cyc[4] - acc_cyc[0] != 4) begin failures++; $display("FAIL full_first_five got=%0d exp=4", acc_cyc[4] - acc_cyc[0]); end
    checks++; if (acc_cyc[5] - acc_cyc[4] != 40 * CPB - 1) begin failures++; $display("FAIL sixth_wait got=%0d exp=%0d", acc_cyc[5] - acc_cyc[4], 40 * CPB - 1); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=0 exp=1"); end
    checks++; if (rx_q.size() != 24) begin failures++; $display("FAIL full_count got=%0d exp=24", rx_q.size()); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin failures++; $display("FAIL full_byte got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_wrap;
    bit ok, all_ok;
    int nexp;
    all_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      push_word($urandom, ok);
      all_ok &= ok;
    end
    nexp = exp_q.size();
    checks++; if (!all_ok) begin failures++; $display("FAIL wrap_push got=0 exp=1"); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=0 exp=1"); end
    checks++; if (rx_q.size() != nexp) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", rx_q.size(), nexp); end
    checks++; if (frame_err != 0) begin failures++; $display("FAIL wrap_framing got=%0d exp=0", frame_err); end
    while (exp_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin failures++; $display("FAIL wrap_byte got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_reset_mid_byte2;
    bit ok, fell;
    int bad;
    fell = 1'b0;
    bad  = 0;
    push_word(32'h1234_5678, ok);
    for (int i = 0; i < 20 && !fell; i++) begin
      if (io_tx === 1'b0) fell = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (!(ok && fell)) begin failures++; $display("FAIL rst2_start got=0 exp=1"); end
    repeat (20 * CPB + CPB + 3 * CPB) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (io_tx !== 1'b1) begin failures++; $display("FAIL rst2_io_tx got=%b exp=1", io_tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst2_busy got=%b exp=0", busy); end
    checks++; if (bus_if.data_ready !== 1'b1) begin failures++; $display("FAIL rst2_ready got=%b exp=1", bus_if.data_ready); end
    exp_q.delete();
    rx_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (io_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rst2_residual got=%0d exp=0", bad); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL rst2_rx got=%0d exp=0", rx_q.size()); end
  endtask

  task automatic test_reset_full_fifo;
    int acc, bad;
    acc = 0;
    bad = 0;
    bus_if.data_valid = 1'b1;
    for (int i = 0; i < 100 && acc < 4; i++) begin
      logic r;
      bus_if.data_in = 32'hC0DE_0000 + acc;
      r = bus_if.data_ready;
      @(posedge clk); #1;
      if (r) acc++;
    end
    bus_if.data_valid = 1'b0;
    checks++; if (acc != 4) begin failures++; $display("FAIL rstf_accepts got=%0d exp=4", acc); end
    repeat (30) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstf_busy got=%b exp=0", busy); end
    checks++; if (io_tx !== 1'b1) begin failures++; $display("FAIL rstf_io_tx got=%b exp=1", io_tx); end
    rx_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (io_tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstf_line got=%0d exp=0", bad); end
    checks++; if (bus_if.data_ready !== 1'b1) begin failures++; $display("FAIL rstf_ready got=%b exp=1", bus_if.data_ready); end
  endtask

  initial begin
    bus_if.data_in    = '0;
    bus_if.data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_single_word();
    test_back_to_back();
    test_full_fifo();
    test_wrap();
    test_reset_mid_byte2();
    test_reset_full_fifo();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
